// File: rtl/trap_sequencer_pkg.sv
// rtl/trap_sequencer_pkg.sv - trap sequencer state encoding and mcause codes
package trap_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_TAKE  = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  localparam logic [3:0] CAUSE_MEI = 4'd11;
  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;

  // Bit positions inside the enabled-interrupt vector handed to int_prio
  localparam int IRQ_MEI = 2;
  localparam int IRQ_MSI = 1;
  localparam int IRQ_MTI = 0;

endpackage

// File: rtl/trap_sequencer_if.sv
// rtl/trap_sequencer_if.sv - interrupt, writeback, redirect and CSR-side trap signals
interface trap_sequencer_if;

  logic        meip_i;
  logic        mtip_i;
  logic        msip_i;
  logic        mstatus_mie_i;
  logic        meie_i;
  logic        mtie_i;
  logic        msie_i;
  logic        exc_valid_i;
  logic [3:0]  exc_code_i;
  logic        wb_valid_i;
  logic [31:0] wb_pc_i;
  logic        redirect_ack_i;

  logic        flush_o;
  logic        trap_take_o;
  logic        trap_is_int_o;
  logic [3:0]  trap_code_o;
  logic [31:0] trap_pc_o;
  logic        busy_o;
  logic        err_o;

  modport master (
    output meip_i, mtip_i, msip_i, mstatus_mie_i, meie_i, mtie_i, msie_i,
    output exc_valid_i, exc_code_i, wb_valid_i, wb_pc_i, redirect_ack_i,
    input  flush_o, trap_take_o, trap_is_int_o, trap_code_o, trap_pc_o, busy_o, err_o
  );

  modport slave (
    input  meip_i, mtip_i, msip_i, mstatus_mie_i, meie_i, mtie_i, msie_i,
    input  exc_valid_i, exc_code_i, wb_valid_i, wb_pc_i, redirect_ack_i,
    output flush_o, trap_take_o, trap_is_int_o, trap_code_o, trap_pc_o, busy_o, err_o
  );

endinterface

// File: rtl/trap_sequencer_int_prio.sv
// rtl/trap_sequencer_int_prio.sv - fixed-priority interrupt encoder, MEI > MSI > MTI
module int_prio
  import trap_sequencer_pkg::*;
(
  input  logic [2:0] en_vec,
  output logic       valid,
  output logic [3:0] code
);

  always_comb begin
    valid = |en_vec;
    code  = '0;
    if (en_vec[IRQ_MEI]) begin
      code = CAUSE_MEI;
    end else if (en_vec[IRQ_MSI]) begin
      code = CAUSE_MSI;
    end else if (en_vec[IRQ_MTI]) begin
      code = CAUSE_MTI;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - sequences one trap at a time: flush, CSR take strobe, wait for fetch redirect
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int TO_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  trap_sequencer_if.slave  bus
);

  // Timeout fires on the WAIT cycle that brings the counter to all-ones
  localparam logic [TO_W-1:0] TO_LAST = {TO_W{1'b1}} - TO_W'(1);

  state_t          state;
  state_t          state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_cnt_nxt;
  logic [3:0]      code_q;
  logic [3:0]      code_nxt;
  logic            is_int_q;
  logic            is_int_nxt;
  logic [31:0]     pc_q;
  logic [31:0]     pc_nxt;
  logic            err_q;
  logic            err_nxt;

  logic [2:0]      irq_en;
  logic            irq_valid;
  logic [3:0]      irq_code;

  assign irq_en = {bus.meip_i & bus.meie_i,
                   bus.msip_i & bus.msie_i,
                   bus.mtip_i & bus.mtie_i} & {3{bus.mstatus_mie_i}};

  int_prio u_int_prio (
    .en_vec (irq_en),
    .valid  (irq_valid),
    .code   (irq_code)
  );

  always_comb begin
    state_nxt  = state;
    to_cnt_nxt = to_cnt;
    code_nxt   = code_q;
    is_int_nxt = is_int_q;
    pc_nxt     = pc_q;
    err_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        // Exceptions outrank interrupts; interrupts only at a retiring instruction
        if (bus.exc_valid_i) begin
          code_nxt   = bus.exc_code_i;
          is_int_nxt = 1'b0;
          pc_nxt     = bus.wb_pc_i;
          state_nxt  = ST_FLUSH;
        end else if (bus.wb_valid_i && irq_valid) begin
          code_nxt   = irq_code;
          is_int_nxt = 1'b1;
          pc_nxt     = bus.wb_pc_i;
          state_nxt  = ST_FLUSH;
        end
      end
      ST_FLUSH: state_nxt = ST_TAKE;
      ST_TAKE: begin
        state_nxt  = ST_WAIT;
        to_cnt_nxt = '0;
      end
      ST_WAIT: begin
        if (bus.redirect_ack_i) begin
          state_nxt = ST_IDLE;
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
          if (to_cnt == TO_LAST) begin
            state_nxt = ST_IDLE;
            err_nxt   = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      to_cnt   <= '0;
      code_q   <= '0;
      is_int_q <= 1'b0;
      pc_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      to_cnt   <= to_cnt_nxt;
      code_q   <= code_nxt;
      is_int_q <= is_int_nxt;
      pc_q     <= pc_nxt;
      err_q    <= err_nxt;
    end
  end

  assign bus.flush_o       = (state != ST_IDLE);
  assign bus.busy_o        = (state != ST_IDLE);
  assign bus.trap_take_o   = (state == ST_TAKE);
  assign bus.trap_code_o   = code_q;
  assign bus.trap_is_int_o = is_int_q;
  assign bus.trap_pc_o     = pc_q;
  assign bus.err_o         = err_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - directed trap scenarios against a cycle-count model of the sequencer
module tb_trap_sequencer;

  localparam int TO_W       = 4;
  localparam int WAIT_LIMIT = (1 << TO_W) - 1;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  trap_sequencer_if bus ();

  trap_sequencer #(.TO_W(TO_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: m_phase counts cycles since the trap was accepted (0 = idle).
  // Phase 1 flush only, phase 2 take strobe, phase >= 3 is wait cycle (m_phase-2).
  int          m_phase = 0;
  bit          m_ready = 0;
  bit          m_err   = 0;
  logic [3:0]  m_code  = '0;
  bit          m_int   = 0;
  logic [31:0] m_pc    = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_err   = 0;
      m_code  = '0;
      m_int   = 0;
      m_pc    = '0;
      m_ready = 1;
    end else begin
      m_err = 0;
      if (m_phase == 0) begin
        if (bus.exc_valid_i) begin
          m_phase = 1;
          m_code  = bus.exc_code_i;
          m_int   = 0;
          m_pc    = bus.wb_pc_i;
        end else if (bus.wb_valid_i && bus.mstatus_mie_i) begin
          if (bus.meip_i && bus.meie_i) begin
            m_phase = 1; m_code = 4'd11; m_int = 1; m_pc = bus.wb_pc_i;
          end else if (bus.msip_i && bus.msie_i) begin
            m_phase = 1; m_code = 4'd3;  m_int = 1; m_pc = bus.wb_pc_i;
          end else if (bus.mtip_i && bus.mtie_i) begin
            m_phase = 1; m_code = 4'd7;  m_int = 1; m_pc = bus.wb_pc_i;
          end
        end
      end else if (m_phase >= 3) begin
        if (bus.redirect_ack_i) begin
          m_phase = 0;
        end else if (m_phase - 2 == WAIT_LIMIT) begin
          m_phase = 0;
          m_err   = 1;
        end else begin
          m_phase = m_phase + 1;
        end
      end else begin
        m_phase = m_phase + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_ready) begin
      chk("m_flush",  32'(bus.flush_o),       32'(m_phase != 0));
      chk("m_busy",   32'(bus.busy_o),        32'(m_phase != 0));
      chk("m_take",   32'(bus.trap_take_o),   32'(m_phase == 2));
      chk("m_err",    32'(bus.err_o),         32'(m_err));
      chk("m_code",   32'(bus.trap_code_o),   32'(m_code));
      chk("m_is_int", 32'(bus.trap_is_int_o), 32'(m_int));
      chk("m_pc",     bus.trap_pc_o,          m_pc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.meip_i = 0; bus.mtip_i = 0; bus.msip_i = 0; bus.mstatus_mie_i = 0;
    bus.meie_i = 0; bus.mtie_i = 0; bus.msie_i = 0;
    bus.exc_valid_i = 0; bus.exc_code_i = '0; bus.wb_valid_i = 0;
    bus.wb_pc_i = '0; bus.redirect_ack_i = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    clear_inputs();
    rst = 1;
    tick(); tick();
    @(negedge clk);
    chk("rst_busy",  32'(bus.busy_o), 0);
    chk("rst_flush", 32'(bus.flush_o), 0);
    chk("rst_code",  32'(bus.trap_code_o), 0);
    chk("rst_pc",    bus.trap_pc_o, 0);
    chk("rst_err",   32'(bus.err_o), 0);
    tick();
    rst = 0;

    // Exception code 2 at pc 0x100
    bus.exc_valid_i = 1; bus.exc_code_i = 4'd2; bus.wb_pc_i = 32'h100;
    tick();
    bus.exc_valid_i = 0;
    @(negedge clk);
    chk("exc_flush_n1", 32'(bus.flush_o), 1);
    chk("exc_take_n1",  32'(bus.trap_take_o), 0);
    tick();
    @(negedge clk);
    chk("exc_take_n2", 32'(bus.trap_take_o), 1);
    chk("exc_code",    32'(bus.trap_code_o), 2);
    chk("exc_is_int",  32'(bus.trap_is_int_o), 0);
    chk("exc_pc",      bus.trap_pc_o, 32'h100);
    tick();
    bus.redirect_ack_i = 1;
    @(negedge clk);
    chk("exc_flush_wait", 32'(bus.flush_o), 1);
    tick();
    bus.redirect_ack_i = 0;
    @(negedge clk);
    chk("exc_idle_n4", 32'(bus.busy_o), 0);

    // All interrupts pending; ack held high through flush/take must be ignored
    bus.meip_i = 1; bus.msip_i = 1; bus.mtip_i = 1;
    bus.meie_i = 1; bus.msie_i = 1; bus.mtie_i = 1; bus.mstatus_mie_i = 1;
    bus.wb_valid_i = 1; bus.wb_pc_i = 32'h200; bus.redirect_ack_i = 1;
    tick();
    bus.meip_i = 0; bus.msip_i = 0; bus.mtip_i = 0; bus.wb_valid_i = 0;
    tick();
    @(negedge clk);
    chk("irq_take",   32'(bus.trap_take_o), 1);
    chk("irq_code",   32'(bus.trap_code_o), 11);
    chk("irq_is_int", 32'(bus.trap_is_int_o), 1);
    chk("irq_pc",     bus.trap_pc_o, 32'h200);
    tick();
    @(negedge clk);
    chk("irq_ack_in_take_ignored", 32'(bus.busy_o), 1);
    tick();
    bus.redirect_ack_i = 0;
    @(negedge clk);
    chk("irq_idle", 32'(bus.busy_o), 0);

    // Pending interrupt without a retiring instruction waits
    bus.meip_i = 1;
    repeat (5) tick();
    @(negedge clk);
    chk("irq_no_wb_idle", 32'(bus.busy_o), 0);
    bus.meip_i = 0;

    // Timer interrupt masked globally, then unmasked
    bus.mstatus_mie_i = 0; bus.mtip_i = 1; bus.wb_valid_i = 1; bus.wb_pc_i = 32'h300;
    repeat (20) tick();
    @(negedge clk);
    chk("mti_masked_idle", 32'(bus.busy_o), 0);
    bus.mstatus_mie_i = 1;
    tick();
    bus.mtip_i = 0; bus.wb_valid_i = 0;
    tick();
    @(negedge clk);
    chk("mti_take", 32'(bus.trap_take_o), 1);
    chk("mti_code", 32'(bus.trap_code_o), 7);
    chk("mti_pc",   bus.trap_pc_o, 32'h300);
    tick();
    bus.redirect_ack_i = 1;
    tick();
    bus.redirect_ack_i = 0;

    // Exception and MEI together: exception first, MEI afterwards
    bus.exc_valid_i = 1; bus.exc_code_i = 4'd4; bus.wb_pc_i = 32'h400;
    bus.meip_i = 1; bus.wb_valid_i = 1;
    tick();
    bus.exc_valid_i = 0;
    tick();
    bus.exc_valid_i = 1; bus.exc_code_i = 4'd9;
    @(negedge clk);
    chk("both_take",   32'(bus.trap_take_o), 1);
    chk("both_code",   32'(bus.trap_code_o), 4);
    chk("both_is_int", 32'(bus.trap_is_int_o), 0);
    tick();
    bus.exc_valid_i = 0; bus.redirect_ack_i = 1;
    tick();
    bus.redirect_ack_i = 0; bus.wb_pc_i = 32'h404;
    @(negedge clk);
    chk("both_idle", 32'(bus.busy_o), 0);
    tick();
    bus.meip_i = 0; bus.wb_valid_i = 0;
    tick();
    @(negedge clk);
    chk("mei_after_take", 32'(bus.trap_take_o), 1);
    chk("mei_after_code", 32'(bus.trap_code_o), 11);
    chk("mei_after_pc",   bus.trap_pc_o, 32'h404);
    tick();
    bus.redirect_ack_i = 1;
    tick();
    bus.redirect_ack_i = 0;

    // Timeout with no ack: 15 wait cycles, then err pulse alongside idle
    bus.exc_valid_i = 1; bus.exc_code_i = 4'd5; bus.wb_pc_i = 32'h500;
    tick();
    bus.exc_valid_i = 0;
    repeat (16) tick();
    @(negedge clk);
    chk("to_last_wait_busy", 32'(bus.busy_o), 1);
    chk("to_last_wait_err",  32'(bus.err_o), 0);
    tick();
    @(negedge clk);
    chk("to_err_pulse", 32'(bus.err_o), 1);
    chk("to_idle",      32'(bus.busy_o), 0);
    tick();
    @(negedge clk);
    chk("to_err_once", 32'(bus.err_o), 0);

    // Ack on the terminal-count cycle wins over the timeout
    bus.exc_valid_i = 1; bus.exc_code_i = 4'd6; bus.wb_pc_i = 32'h600;
    tick();
    bus.exc_valid_i = 0;
    repeat (15) tick();
    tick();
    bus.redirect_ack_i = 1;
    tick();
    bus.redirect_ack_i = 0;
    @(negedge clk);
    chk("ack_term_no_err", 32'(bus.err_o), 0);
    chk("ack_term_idle",   32'(bus.busy_o), 0);

    // Reset while in TAKE overrides simultaneous exception and ack
    bus.exc_valid_i = 1; bus.exc_code_i = 4'd8; bus.wb_pc_i = 32'h700;
    tick();
    bus.exc_valid_i = 0;
    tick();
    rst = 1; bus.exc_valid_i = 1; bus.redirect_ack_i = 1;
    @(negedge clk);
    chk("rst_mid_take", 32'(bus.trap_take_o), 1);
    tick();
    rst = 0; bus.exc_valid_i = 0; bus.redirect_ack_i = 0;
    @(negedge clk);
    chk("rst_mid_busy",   32'(bus.busy_o), 0);
    chk("rst_mid_take0",  32'(bus.trap_take_o), 0);
    chk("rst_mid_code",   32'(bus.trap_code_o), 0);
    chk("rst_mid_pc",     bus.trap_pc_o, 0);
    chk("rst_mid_is_int", 32'(bus.trap_is_int_o), 0);

    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
